inst_buffer_queue: RTL
======================

// Module: inst_buffer_queue
// PURPOSE
//  Decoupling FIFO between fetch/decode and rename. Accepts up to FETCH_WIDTH decoded
//  packets per cycle (sparse valid mask, compacted in lane order).
//  Releases exactly DISPATCH_WIDTH packets per cycle to rename, bundle-atomic.
//  Drives instBufferFull_o, which is the fetch-side stall (Fetch1/Fetch2 pipeline hold).
// PARAMETERS
//  FETCH_WIDTH     4   write lanes per cycle
//  DISPATCH_WIDTH  4   read lanes per cycle; <= DEPTH
//  DEPTH           32  entries; power of 2, >= FETCH_WIDTH + DISPATCH_WIDTH
//  PKT_W           64  bits per decoded packet
// PORTS
//  clk               in   1                       clock, rising edge
//  reset             in   1                       asynchronous, active-high
//  flush_i           in   1                       sync clear (recover/exception/fetch reset)
//  wrEn_i            in   1                       write bundle present
//  wrValid_i         in   FETCH_WIDTH             per-lane valid; sparse allowed
//  wrPkt_i           in   FETCH_WIDTH*PKT_W       lane i at [i*PKT_W +: PKT_W]
//  rdReady_i         in   1                       rename can accept a bundle this cycle
//  rdValid_o         out  1                       DISPATCH_WIDTH packets available at head
//  rdPkt_o           out  DISPATCH_WIDTH*PKT_W    head..head+DISPATCH_WIDTH-1, oldest in lane 0
//  instBufferFull_o  out  1                       free entries < FETCH_WIDTH
//  count_o           out  $clog2(DEPTH)+1         occupied entries
// BEHAVIOUR
//  State: storage[DEPTH], headPtr and tailPtr ($clog2(DEPTH) bits, wrap mod DEPTH), count.
//  Reset (async, reset=1): headPtr=0, tailPtr=0, count=0. Outputs: rdValid_o=0,
//   instBufferFull_o=0, count_o=0, rdPkt_o=0. Storage is not reset.
//  Write accept: wrAcc = wrEn_i & ~instBufferFull_o & ~flush_i.
//   - nWr = popcount(wrValid_i), range 0..FETCH_WIDTH.
//   - Valid lanes are compacted in ascending lane order into storage[tailPtr+k mod DEPTH],
//     k = 0..nWr-1.
//   - On the next edge, tailPtr += nWr, with modulo wrap.
//   - If wrEn_i=1 while full, the bundle is dropped. This is an upstream protocol error;
//     assert it in simulation.
//  Read fire: rdFire = rdValid_o & rdReady_i & ~flush_i. On fire, headPtr += DISPATCH_WIDTH
//   (mod DEPTH).
//  rdValid_o = (count >= DISPATCH_WIDTH). Combinational from registered count; no
//   partial bundles.
//  rdPkt_o = storage[headPtr+j mod DEPTH] for j = 0..DISPATCH_WIDTH-1 when rdValid_o;
//   else all zero.
//  Latency: a packet written at edge N is visible on rdPkt_o in the cycle after edge N.
//   Minimum write-to-dispatch is 1 cycle.
//  count_next = count + (wrAcc ? nWr : 0) - (rdFire ? DISPATCH_WIDTH : 0).
//   - Simultaneous read and write are allowed in the same cycle.
//   - Read uses pre-write contents; the same-cycle write never bypasses to rdPkt_o.
//   - The free check uses the current count; the same-cycle read does not free space for
//     the write.
//  instBufferFull_o = (DEPTH - count) < FETCH_WIDTH. Combinational from registered count.
//  flush_i has priority over read and write in the same cycle: headPtr=tailPtr=0,
//   count=0 at the next edge.
//  Async reset asserted mid-operation: state clears immediately. Outputs reach reset
//   values in the same cycle.
//  Wrap-around: write and read spans that cross DEPTH-1 -> 0 must be contiguous and
//   order-preserving.
//  Invariants: 0 <= count <= DEPTH, and count == (tailPtr - headPtr) mod DEPTH unless
//   count == DEPTH.
// TESTING
//  1. Reset, then wrValid_i=4'b1111 on 2 cycles with rdReady_i=0
//     -> count_o=8, rdValid_o=1, lane 0 = first pkt.
//  2. wrValid_i=4'b1010 (pkts A@lane1, B@lane3) then 4'b0101 (C, D)
//     -> rdPkt_o = {A,B,C,D} in lanes 0..3.
//  3. Fill to count=29 (DEPTH=32) -> instBufferFull_o=1. Next wrEn_i is ignored,
//     count stays 29. One read -> count=25, full=0.
//  4. Stream with headPtr=30 and tailPtr wrapping past 31
//     -> output order preserved across the wrap; count_o matches the reference model.
//  5. count=12, wrEn_i plus rdFire plus flush_i in the same cycle
//     -> count_o=0, rdValid_o=0 next cycle.
//  6. Assert async reset between edges at count=16
//     -> outputs go to reset values before the next edge; resume after release.

Source files
------------

// File: rtl/inst_buffer_queue.sv
// ---------------------------------------------------------------------------
// inst_buffer_queue
//   Decoupling FIFO between fetch/decode and rename. Up to FETCH_WIDTH decoded
//   packets enter per cycle under a sparse valid mask. Valid lanes are packed
//   into consecutive slots in lane order. Rename drains exactly DISPATCH_WIDTH
//   packets per cycle, whole bundles only.
//
// Ports
//   clk               rising-edge clock
//   reset             asynchronous, active-high reset of pointers and count
//   flush_i           synchronous clear; wins over read and write in the same cycle
//   wrEn_i            a write bundle is present
//   wrValid_i         per-lane valid mask (sparse allowed)
//   wrPkt_i           lane i packet at [i*PKT_W +: PKT_W]
//   rdReady_i         rename accepts a bundle this cycle
//   rdValid_o         at least DISPATCH_WIDTH packets are held
//   rdPkt_o           oldest DISPATCH_WIDTH packets, oldest in lane 0; zero when !rdValid_o
//   instBufferFull_o  fewer than FETCH_WIDTH free entries (fetch stall)
//   count_o           occupied entries
// ---------------------------------------------------------------------------

// Protocol checker: a write bundle offered while the queue is full is dropped,
// which indicates an upstream stall bug.
module inst_buffer_queue_chk #(
  parameter int DEPTH = 32,
  parameter int CNT_W = 6
) (
  input logic             clk,
  input logic             reset,
  input logic             flush,
  input logic             wr_en,
  input logic             full,
  input logic [CNT_W-1:0] count
);

  // Sample the handshake on each clock edge while out of reset.
  always @(posedge clk) begin
    if (!reset) begin
      assert (!(wr_en && full && !flush))
        else $error("inst_buffer_queue: write bundle dropped while full");
      assert (count <= CNT_W'(DEPTH))
        else $error("inst_buffer_queue: occupancy above DEPTH");
    end
  end

endmodule

module inst_buffer_queue #(
  parameter int FETCH_WIDTH    = 4,
  parameter int DISPATCH_WIDTH = 4,
  parameter int DEPTH          = 32,
  parameter int PKT_W          = 64,
  parameter bit ASSERT_ON      = 1'b1
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            flush_i,
  input  logic                            wrEn_i,
  input  logic [FETCH_WIDTH-1:0]          wrValid_i,
  input  logic [FETCH_WIDTH*PKT_W-1:0]    wrPkt_i,
  input  logic                            rdReady_i,
  output logic                            rdValid_o,
  output logic [DISPATCH_WIDTH*PKT_W-1:0] rdPkt_o,
  output logic                            instBufferFull_o,
  output logic [$clog2(DEPTH):0]          count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int OFF_W = $clog2(FETCH_WIDTH + 1);

  logic [PKT_W-1:0] storage_r [DEPTH];
  logic [PTR_W-1:0] head_r;
  logic [PTR_W-1:0] tail_r;
  logic [CNT_W-1:0] count_r;

  logic [OFF_W-1:0] lane_off_s [FETCH_WIDTH];
  logic [OFF_W-1:0] n_wr_s;
  logic [CNT_W-1:0] free_s;
  logic             wr_acc_s;
  logic             rd_fire_s;

  // Status flags derive only from the registered count, so async reset
  // drives them to their idle values without waiting for a clock.
  always_comb begin
    free_s           = CNT_W'(DEPTH) - count_r;
    instBufferFull_o = (free_s < CNT_W'(FETCH_WIDTH));
    rdValid_o        = (count_r >= CNT_W'(DISPATCH_WIDTH));
    count_o          = count_r;
    wr_acc_s         = wrEn_i & ~instBufferFull_o & ~flush_i;
    rd_fire_s        = rdValid_o & rdReady_i & ~flush_i;
  end

  // Compaction: each valid lane lands at an offset equal to the number of
  // valid lanes below it, so packets stay contiguous and in lane order.
  always_comb begin
    logic [OFF_W-1:0] acc;
    acc = {OFF_W{1'b0}};
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      lane_off_s[i] = acc;
      acc           = acc + OFF_W'(wrValid_i[i]);
    end
    n_wr_s = acc;
  end

  // Packet storage is intentionally not reset; pointer arithmetic wraps
  // naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      if (wr_acc_s && wrValid_i[i]) begin
        storage_r[tail_r + PTR_W'(lane_off_s[i])] <= wrPkt_i[i*PKT_W +: PKT_W];
      end
    end
  end

  // Pointer and occupancy update; flush clears everything and overrides a
  // same-cycle read or write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_r  <= {PTR_W{1'b0}};
      tail_r  <= {PTR_W{1'b0}};
      count_r <= {CNT_W{1'b0}};
    end else if (flush_i) begin
      head_r  <= {PTR_W{1'b0}};
      tail_r  <= {PTR_W{1'b0}};
      count_r <= {CNT_W{1'b0}};
    end else begin
      head_r  <= head_r + (rd_fire_s ? PTR_W'(DISPATCH_WIDTH) : {PTR_W{1'b0}});
      tail_r  <= tail_r + (wr_acc_s ? PTR_W'(n_wr_s) : {PTR_W{1'b0}});
      count_r <= count_r
               + (wr_acc_s  ? CNT_W'(n_wr_s)         : {CNT_W{1'b0}})
               - (rd_fire_s ? CNT_W'(DISPATCH_WIDTH) : {CNT_W{1'b0}});
    end
  end

  // Head bundle read straight from storage; the same-cycle write is only
  // visible after the edge, so there is no bypass path.
  always_comb begin
    rdPkt_o = {(DISPATCH_WIDTH*PKT_W){1'b0}};
    if (rdValid_o) begin
      for (int j = 0; j < DISPATCH_WIDTH; j++) begin
        rdPkt_o[j*PKT_W +: PKT_W] = storage_r[head_r + PTR_W'(j)];
      end
    end else begin
      rdPkt_o = {(DISPATCH_WIDTH*PKT_W){1'b0}};
    end
  end

  generate
    if (ASSERT_ON) begin : g_chk
      inst_buffer_queue_chk #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
      ) u_chk (
        .clk   (clk),
        .reset (reset),
        .flush (flush_i),
        .wr_en (wrEn_i),
        .full  (instBufferFull_o),
        .count (count_r)
      );
    end
  endgenerate

endmodule
